// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC post-processing block.
//   N_FRAC_DEFAULT : default fraction bits (words are N_FRAC+1 bits signed)
//   GAIN_GUARD     : guard bits prepended below the operand LSB
//   N_TERMS        : number of shift-add gain terms
//   TERM_SHIFT/NEG : per-term right shift and subtract flag, index 0..3
//   state_e        : FSM state encodings
package cordic_pkg;

   localparam int unsigned N_FRAC_DEFAULT = 7;
   localparam int unsigned GAIN_GUARD     = 9;
   localparam int unsigned N_TERMS        = 4;

   // 1/K ~= 1/2 + 1/8 - 1/64 - 1/512 = 311/512
   localparam logic [N_TERMS-1:0][3:0] TERM_SHIFT = {4'd9, 4'd6, 4'd3, 4'd1};
   localparam logic [N_TERMS-1:0]      TERM_NEG   = 4'b1100;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StScale = 2'b01,
      StHold  = 2'b10
   } state_e;

endpackage

// File: rtl/cordic_gain_acc.sv
// Per-axis gain compensation: captures one operand, accumulates one shifted
// term per step, and presents the rounded sum including the current term.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture data_i and clear the accumulator
//   data_i       : signed raw operand
//   step_i       : add term term_i to the accumulator
//   term_i       : term index 0..N_TERMS-1
//   result_o     : round-half-up of (acc + current term), N_FRAC+1 bits
module cordic_gain_acc
   import cordic_pkg::*;
#(
   parameter int unsigned N_FRAC = N_FRAC_DEFAULT
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic signed [N_FRAC:0] data_i,
   input  logic                step_i,
   input  logic [1:0]          term_i,
   output logic signed [N_FRAC:0] result_o
);

   localparam int unsigned AW = N_FRAC + 11;
   localparam logic signed [AW-1:0] HALF = AW'(1) <<< (GAIN_GUARD - 1);

   logic signed [AW-1:0] opnd_q, opnd_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AW-1:0] term, sum;

   always_comb begin
      // Operand carries GAIN_GUARD zero LSBs, so every right shift is exact.
      term = opnd_q >>> TERM_SHIFT[term_i];
      if (TERM_NEG[term_i]) begin
         term = -term;
      end
      sum = acc_q + term;

      opnd_d = opnd_q;
      acc_d  = acc_q;
      if (load_i) begin
         opnd_d = AW'(data_i) <<< GAIN_GUARD;
         acc_d  = '0;
      end else if (step_i) begin
         acc_d = sum;
      end
   end

   assign result_o = N_FRAC'(1) == 0 ? '0 : (N_FRAC + 1)'((sum + HALF) >>> GAIN_GUARD);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         opnd_q <= '0;
         acc_q  <= '0;
      end else begin
         opnd_q <= opnd_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/cordic_postproc.sv
// CORDIC post-processor: multiplies x/y by 1/K (311/512) with four shift-add
// terms, rounds half-up, passes z through, and holds the word until accepted.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   x_i, y_i, z_i           : signed raw CORDIC results
//   data_in_valid_strobe_i  : one-cycle pulse qualifying the inputs
//   x_o, y_o, z_o           : registered compensated x/y, pass-through z
//   data_out_valid_o        : output word valid (HOLD)
//   data_out_ready_i        : consumer accept
//   busy_o                  : state is not IDLE
//   overrun_o               : sticky, an input strobe was dropped
module cordic_postproc
   import cordic_pkg::*;
#(
   parameter int unsigned N_FRAC = N_FRAC_DEFAULT
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic signed [N_FRAC:0] x_i,
   input  logic signed [N_FRAC:0] y_i,
   input  logic signed [N_FRAC:0] z_i,
   input  logic                   data_in_valid_strobe_i,
   output logic signed [N_FRAC:0] x_o,
   output logic signed [N_FRAC:0] y_o,
   output logic signed [N_FRAC:0] z_o,
   output logic                   data_out_valid_o,
   input  logic                   data_out_ready_i,
   output logic                   busy_o,
   output logic                   overrun_o
);

   state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic signed [N_FRAC:0] x_q, x_d, y_q, y_d, z_q, z_d, zraw_q, zraw_d;
   logic valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;
   logic load, step;
   logic signed [N_FRAC:0] x_res, y_res;

   cordic_gain_acc #(.N_FRAC(N_FRAC)) u_acc_x (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load),
      .data_i  (x_i),
      .step_i  (step),
      .term_i  (cnt_q),
      .result_o(x_res)
   );

   cordic_gain_acc #(.N_FRAC(N_FRAC)) u_acc_y (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load),
      .data_i  (y_i),
      .step_i  (step),
      .term_i  (cnt_q),
      .result_o(y_res)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      zraw_d  = zraw_q;
      ovr_d   = ovr_q;
      load    = 1'b0;
      step    = 1'b0;

      case (state_q)
         StIdle: begin
            if (data_in_valid_strobe_i) begin
               load    = 1'b1;
               zraw_d  = z_i;
               cnt_d   = '0;
               state_d = StScale;
            end
         end
         StScale: begin
            step  = 1'b1;
            cnt_d = cnt_q + 2'd1;
            if (data_in_valid_strobe_i) begin
               ovr_d = 1'b1;
            end
            if (cnt_q == 2'(N_TERMS - 1)) begin
               x_d     = x_res;
               y_d     = y_res;
               z_d     = zraw_q;
               state_d = StHold;
            end
         end
         StHold: begin
            if (data_out_ready_i) begin
               // A strobe on the handshake cycle starts the next word directly.
               if (data_in_valid_strobe_i) begin
                  load    = 1'b1;
                  zraw_d  = z_i;
                  cnt_d   = '0;
                  state_d = StScale;
               end else begin
                  state_d = StIdle;
               end
            end else if (data_in_valid_strobe_i) begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      valid_d = (state_d == StHold);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         zraw_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         zraw_q  <= zraw_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign x_o              = x_q;
   assign y_o              = y_q;
   assign z_o              = z_q;
   assign data_out_valid_o = valid_q;
   assign busy_o           = busy_q;
   assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_cordic_postproc.sv
// Randomized self-checking bench for cordic_postproc with a countdown-based
// behavioural model and literal checks on hand-computed words.
module tb_cordic_postproc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [7:0] x_i = '0, y_i = '0, z_i = '0;
   logic strobe = 1'b0;
   logic ready = 1'b0;
   logic signed [7:0] x_o, y_o, z_o;
   logic valid, busy, ovr;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   cordic_postproc #(.N_FRAC(7)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .x_i                   (x_i),
      .y_i                   (y_i),
      .z_i                   (z_i),
      .data_in_valid_strobe_i(strobe),
      .x_o                   (x_o),
      .y_o                   (y_o),
      .z_o                   (z_o),
      .data_out_valid_o      (valid),
      .data_out_ready_i      (ready),
      .busy_o                (busy),
      .overrun_o             (ovr)
   );

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // x * (1/K) with 1/K = 311/512, rounded half-up (floor of value + 1/2).
   function automatic int gain(input int v);
      return (v * 311 + 256) >>> 9;
   endfunction

   // Model: a word is in flight for 4 cycles after acceptance, then held.
   int m_cd = 0;
   logic m_valid = 1'b0, m_busy = 1'b0, m_ovr = 1'b0;
   logic signed [7:0] m_x = '0, m_y = '0, m_z = '0;
   logic signed [7:0] m_px = '0, m_py = '0, m_pz = '0;

   always @(posedge clk) begin : mdl
      int cd;
      logic v, o, hs;
      logic signed [7:0] nx, ny, nz;
      cd = m_cd; v = m_valid; o = m_ovr; nx = m_x; ny = m_y; nz = m_z;
      hs = m_valid && ready;
      if (m_cd != 0) begin
         cd = m_cd - 1;
         if (cd == 0) begin
            nx = m_px; ny = m_py; nz = m_pz; v = 1'b1;
         end
      end
      if (hs) v = 1'b0;
      if (strobe) begin
         if (!m_busy || hs) begin
            cd = 4;
            m_px <= 8'(gain(int'(x_i)));
            m_py <= 8'(gain(int'(y_i)));
            m_pz <= z_i;
         end else begin
            o = 1'b1;
         end
      end
      if (rst) begin
         cd = 0; v = 1'b0; o = 1'b0; nx = '0; ny = '0; nz = '0;
      end
      m_cd    <= cd;
      m_valid <= v;
      m_ovr   <= o;
      m_busy  <= (cd != 0) || v;
      m_x     <= nx;
      m_y     <= ny;
      m_z     <= nz;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid", valid, m_valid);
         check("busy", busy, m_busy);
         check("overrun", ovr, m_ovr);
         check("x_o", x_o, m_x);
         check("y_o", y_o, m_y);
         check("z_o", z_o, m_z);
      end
   end

   // Strobe one word, measure latency, check literal results, hold, handshake.
   task automatic word(input int xv, input int yv, input int zv, input int ex,
                       input int ey, input int hold);
      int lat;
      @(negedge clk);
      x_i = 8'(xv); y_i = 8'(yv); z_i = 8'(zv); strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      lat = 1;
      while (!valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 5);
      check("x_lit", x_o, ex);
      check("y_lit", y_o, ey);
      check("z_lit", z_o, zv);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_x", x_o, ex);
         check("hold_valid", valid, 1);
         check("hold_busy", busy, 1);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check("valid_drop", valid, 0);
   endtask

   initial begin
      int lat;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_x", x_o, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", ovr, 0);

      word(127, 0, 32, 77, 0, 0);
      word(-128, 64, 5, -78, 39, 0);
      word(1, -64, -7, 1, -39, 10);

      // Second strobe during SCALE is dropped.
      @(negedge clk);
      x_i = 8'sd100; y_i = -8'sd100; z_i = 8'sd9; strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      @(negedge clk);
      x_i = 8'sd5; y_i = 8'sd5; z_i = 8'sd1; strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      check("ovr_set", ovr, 1);
      lat = 3;
      while (!valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("ovr_latency", lat, 5);
      check("ovr_x", x_o, 61);
      check("ovr_y", y_o, -61);
      check("ovr_z", z_o, 9);
      // Strobe on the handshake cycle is accepted.
      x_i = -8'sd1; y_i = 8'sd127; z_i = -8'sd3; strobe = 1'b1; ready = 1'b1;
      @(negedge clk);
      strobe = 1'b0; ready = 1'b0;
      check("hs_valid", valid, 0);
      check("hs_busy", busy, 1);
      check("hs_ovr", ovr, 1);
      lat = 1;
      while (!valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("hs_latency", lat, 5);
      check("hs_x", x_o, -1);
      check("hs_y", y_o, 77);
      check("hs_z", z_o, -3);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;

      // Reset in cycle 3 of SCALE, with a coincident strobe.
      x_i = 8'sd50; y_i = 8'sd50; z_i = 8'sd50; strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; strobe = 1'b1;
      @(negedge clk);
      rst = 1'b0; strobe = 1'b0;
      check("abort_x", x_o, 0);
      check("abort_z", z_o, 0);
      check("abort_valid", valid, 0);
      check("abort_busy", busy, 0);
      check("abort_ovr", ovr, 0);
      repeat (8) begin
         @(negedge clk);
         check("abort_novalid", valid, 0);
      end
      word(-128, 64, 0, -78, 39, 0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         x_i = 8'($urandom);
         y_i = 8'($urandom);
         z_i = 8'($urandom);
         strobe = ($urandom_range(0, 3) == 0);
         ready = ($urandom_range(0, 1) == 1);
         rst = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      strobe = 1'b0; ready = 1'b0; rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
